axi_mem_if_slave: RTL and testbench

//  AXI4 slave that bridges full AXI4 read/write bursts onto one single-port synchronous SRAM
//  (CEN/WEN active-low, byte enables, 1-cycle read latency).

---
 rtl/axi_mem_if_pkg.sv | 27 ++
 rtl/axi_mem_if_rfifo.sv | 56 +++++
 rtl/axi_mem_if_slave.sv | 252 +++++++++++++++++++++++++
 tb/tb_axi_mem_if_slave.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_mem_if_pkg.sv
// Shared types and helpers for the AXI4-to-SRAM slave bridge.
// Burst encodings, response codes, FSM state and the burst address stepper.
package axi_mem_if_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  typedef enum logic [1:0] {StIdle, StRead, StWrite, StWresp} state_e;

  // Byte address of the next beat; callers truncate to their address width so INCR wraps modulo 2^W.
  function automatic logic [63:0] next_addr(input logic [63:0] addr, input logic [7:0] len,
                                            input logic [2:0] size, input logic [1:0] burst);
    logic [63:0] incr;
    logic [63:0] mask;
    incr = 64'd1 << size;
    mask = ((64'(len) + 64'd1) << size) - 64'd1;
    case (burst)
      BURST_FIXED: next_addr = addr;
      BURST_WRAP:  next_addr = (addr & ~mask) | ((addr + incr) & mask);
      default:     next_addr = addr + incr;
    endcase
  endfunction

endpackage

// File: rtl/axi_mem_if_rfifo.sv
// Small synchronous FIFO holding read beats (data plus last flag) for the R channel.
// Output is the head entry, so it stays stable until popped.
module axi_mem_if_rfifo #(
  parameter int unsigned Width = 65,
  parameter int unsigned Depth = 4,
  localparam int unsigned PtrW = $clog2(Depth),
  localparam int unsigned CntW = $clog2(Depth + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [Width-1:0] data_i,
  input  logic             pop_i,
  output logic [Width-1:0] data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CntW-1:0]  count_o
);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q;
  logic             do_push, do_pop;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
  endfunction

  assign full_o  = (count_q == CntW'(Depth));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < int'(Depth); i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= ptr_inc(wr_ptr_q);
      end
      if (do_pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/axi_mem_if_slave.sv
// AXI4 slave serving one read or write burst at a time onto a single-port synchronous SRAM.
// Reads are throttled so issued-but-unreturned data always fits in the R FIFO.
module axi_mem_if_slave
  import axi_mem_if_pkg::*;
#(
  parameter int unsigned AXI4_ADDRESS_WIDTH = 32,
  parameter int unsigned AXI4_RDATA_WIDTH   = 64,
  parameter int unsigned AXI4_WDATA_WIDTH   = 64,
  parameter int unsigned AXI4_ID_WIDTH      = 16,
  parameter int unsigned AXI4_USER_WIDTH    = 10,
  parameter int unsigned MEM_ADDR_WIDTH     = 13,
  parameter int unsigned BUFF_DEPTH_SLAVE   = 4
) (
  input  logic                          ACLK,
  input  logic                          ARESET,
  input  logic                          test_en_i,
  input  logic                          AWVALID_i,
  output logic                          AWREADY_o,
  input  logic [AXI4_ADDRESS_WIDTH-1:0] AWADDR_i,
  input  logic [7:0]                    AWLEN_i,
  input  logic [2:0]                    AWSIZE_i,
  input  logic [1:0]                    AWBURST_i,
  input  logic [AXI4_ID_WIDTH-1:0]      AWID_i,
  input  logic [AXI4_USER_WIDTH-1:0]    AWUSER_i,
  input  logic [2:0]                    AWPROT_i,
  input  logic [3:0]                    AWREGION_i,
  input  logic                          AWLOCK_i,
  input  logic [3:0]                    AWCACHE_i,
  input  logic [3:0]                    AWQOS_i,
  input  logic                          ARVALID_i,
  output logic                          ARREADY_o,
  input  logic [AXI4_ADDRESS_WIDTH-1:0] ARADDR_i,
  input  logic [7:0]                    ARLEN_i,
  input  logic [2:0]                    ARSIZE_i,
  input  logic [1:0]                    ARBURST_i,
  input  logic [AXI4_ID_WIDTH-1:0]      ARID_i,
  input  logic [AXI4_USER_WIDTH-1:0]    ARUSER_i,
  input  logic [2:0]                    ARPROT_i,
  input  logic [3:0]                    ARREGION_i,
  input  logic                          ARLOCK_i,
  input  logic [3:0]                    ARCACHE_i,
  input  logic [3:0]                    ARQOS_i,
  input  logic                          WVALID_i,
  output logic                          WREADY_o,
  input  logic [AXI4_WDATA_WIDTH-1:0]   WDATA_i,
  input  logic [AXI4_WDATA_WIDTH/8-1:0] WSTRB_i,
  input  logic                          WLAST_i,
  input  logic [AXI4_USER_WIDTH-1:0]    WUSER_i,
  output logic                          RVALID_o,
  input  logic                          RREADY_i,
  output logic [AXI4_RDATA_WIDTH-1:0]   RDATA_o,
  output logic [1:0]                    RRESP_o,
  output logic                          RLAST_o,
  output logic [AXI4_ID_WIDTH-1:0]      RID_o,
  output logic [AXI4_USER_WIDTH-1:0]    RUSER_o,
  output logic                          BVALID_o,
  input  logic                          BREADY_i,
  output logic [1:0]                    BRESP_o,
  output logic [AXI4_ID_WIDTH-1:0]      BID_o,
  output logic [AXI4_USER_WIDTH-1:0]    BUSER_o,
  output logic                          CEN,
  output logic                          WEN,
  output logic [MEM_ADDR_WIDTH-1:0]     A,
  output logic [AXI4_WDATA_WIDTH-1:0]   D,
  output logic [AXI4_WDATA_WIDTH/8-1:0] BE,
  input  logic [AXI4_RDATA_WIDTH-1:0]   Q
);

  localparam int unsigned CntW  = $clog2(BUFF_DEPTH_SLAVE + 1);
  localparam int unsigned FifoW = AXI4_RDATA_WIDTH + 1;

  state_e                        state_q, state_d;
  logic [AXI4_ADDRESS_WIDTH-1:0] addr_q, addr_d, addr_nxt;
  logic [7:0]                    len_q, len_d, beat_q, beat_d;
  logic [2:0]                    size_q, size_d;
  logic [1:0]                    burst_q, burst_d;
  logic [AXI4_ID_WIDTH-1:0]      rid_q, rid_d, bid_q, bid_d;
  logic [AXI4_USER_WIDTH-1:0]    ruser_q, ruser_d, buser_q, buser_d;
  logic                          rr_q, rr_d;
  logic                          rd_pend_q, rd_pend_d, rd_last_q, rd_last_d;
  logic                          fifo_full, fifo_empty;
  logic [CntW-1:0]               fifo_count;
  logic [FifoW-1:0]              fifo_rdata;
  logic                          ar_ok, grant_rd, grant_wr, last_beat;

  logic unused_ok;
  assign unused_ok = ^{test_en_i, AWPROT_i, AWREGION_i, AWLOCK_i, AWCACHE_i, AWQOS_i, ARPROT_i,
                       ARREGION_i, ARLOCK_i, ARCACHE_i, ARQOS_i, WLAST_i, WUSER_i, fifo_full};

  assign addr_nxt  = AXI4_ADDRESS_WIDTH'(next_addr(64'(addr_q), len_q, size_q, burst_q));
  assign last_beat = (beat_q == len_q);
  // A new read waits until every beat of the previous one has left the FIFO.
  assign ar_ok     = ARVALID_i && fifo_empty && !rd_pend_q;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    len_d     = len_q;
    beat_d    = beat_q;
    size_d    = size_q;
    burst_d   = burst_q;
    rid_d     = rid_q;
    ruser_d   = ruser_q;
    bid_d     = bid_q;
    buser_d   = buser_q;
    rr_d      = rr_q;
    rd_pend_d = 1'b0;
    rd_last_d = rd_last_q;
    grant_rd  = 1'b0;
    grant_wr  = 1'b0;
    AWREADY_o = 1'b0;
    ARREADY_o = 1'b0;
    WREADY_o  = 1'b0;
    BVALID_o  = 1'b0;
    CEN       = 1'b1;
    WEN       = 1'b1;
    A         = '0;
    D         = '0;
    BE        = '0;
    unique case (state_q)
      StIdle: begin
        if (ar_ok && AWVALID_i) begin
          grant_rd = !rr_q;
          grant_wr = rr_q;
          rr_d     = !rr_q;
        end else begin
          grant_rd = ar_ok;
          grant_wr = AWVALID_i;
        end
        if (grant_rd) begin
          ARREADY_o = 1'b1;
          addr_d    = ARADDR_i;
          len_d     = ARLEN_i;
          size_d    = ARSIZE_i;
          burst_d   = ARBURST_i;
          rid_d     = ARID_i;
          ruser_d   = ARUSER_i;
          beat_d    = '0;
          state_d   = StRead;
        end else if (grant_wr) begin
          AWREADY_o = 1'b1;
          addr_d    = AWADDR_i;
          len_d     = AWLEN_i;
          size_d    = AWSIZE_i;
          burst_d   = AWBURST_i;
          bid_d     = AWID_i;
          buser_d   = AWUSER_i;
          beat_d    = '0;
          state_d   = StWrite;
        end
      end
      StRead: begin
        if (int'(fifo_count) + int'(rd_pend_q) < int'(BUFF_DEPTH_SLAVE)) begin
          CEN       = 1'b0;
          A         = addr_q[MEM_ADDR_WIDTH+2:3];
          addr_d    = addr_nxt;
          beat_d    = beat_q + 8'd1;
          rd_pend_d = 1'b1;
          rd_last_d = last_beat;
          if (last_beat) state_d = StIdle;
        end
      end
      StWrite: begin
        WREADY_o = 1'b1;
        if (WVALID_i) begin
          CEN    = 1'b0;
          WEN    = 1'b0;
          A      = addr_q[MEM_ADDR_WIDTH+2:3];
          D      = WDATA_i;
          BE     = WSTRB_i;
          addr_d = addr_nxt;
          beat_d = beat_q + 8'd1;
          if (last_beat) state_d = StWresp;
        end
      end
      StWresp: begin
        BVALID_o = 1'b1;
        if (BREADY_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    if (ARESET) begin
      AWREADY_o = 1'b0;
      ARREADY_o = 1'b0;
      WREADY_o  = 1'b0;
      BVALID_o  = 1'b0;
      CEN       = 1'b1;
      WEN       = 1'b1;
      A         = '0;
      D         = '0;
      BE        = '0;
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q   <= StIdle;
      addr_q    <= '0;
      len_q     <= '0;
      beat_q    <= '0;
      size_q    <= '0;
      burst_q   <= '0;
      rid_q     <= '0;
      ruser_q   <= '0;
      bid_q     <= '0;
      buser_q   <= '0;
      rr_q      <= 1'b0;
      rd_pend_q <= 1'b0;
      rd_last_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      len_q     <= len_d;
      beat_q    <= beat_d;
      size_q    <= size_d;
      burst_q   <= burst_d;
      rid_q     <= rid_d;
      ruser_q   <= ruser_d;
      bid_q     <= bid_d;
      buser_q   <= buser_d;
      rr_q      <= rr_d;
      rd_pend_q <= rd_pend_d;
      rd_last_q <= rd_last_d;
    end
  end

  axi_mem_if_rfifo #(
    .Width(FifoW),
    .Depth(BUFF_DEPTH_SLAVE)
  ) u_rfifo (
    .clk_i  (ACLK),
    .rst_i  (ARESET),
    .push_i (rd_pend_q),
    .data_i ({rd_last_q, Q}),
    .pop_i  (RVALID_o && RREADY_i),
    .data_o (fifo_rdata),
    .full_o (fifo_full),
    .empty_o(fifo_empty),
    .count_o(fifo_count)
  );

  assign RVALID_o = !fifo_empty && !ARESET;
  assign RDATA_o  = ARESET ? '0 : fifo_rdata[AXI4_RDATA_WIDTH-1:0];
  assign RLAST_o  = fifo_rdata[AXI4_RDATA_WIDTH];
  assign RRESP_o  = RESP_OKAY;
  assign RID_o    = rid_q;
  assign RUSER_o  = ruser_q;
  assign BRESP_o  = RESP_OKAY;
  assign BID_o    = bid_q;
  assign BUSER_o  = buser_q;

endmodule

// File: tb/tb_axi_mem_if_slave.sv
// Directed bench for axi_mem_if_slave with a behavioural 1-cycle-latency SRAM.
// Expected values are hand-computed constants.
module tb_axi_mem_if_slave;

  typedef struct {
    logic [63:0] d;
    logic        l;
    logic [15:0] id;
    logic [9:0]  user;
    logic [1:0]  resp;
  } rbeat_t;

  logic        clk, ARESET, test_en;
  logic        AWVALID, AWREADY, AWLOCK, ARVALID, ARREADY, ARLOCK;
  logic [31:0] AWADDR, ARADDR;
  logic [7:0]  AWLEN, ARLEN;
  logic [2:0]  AWSIZE, ARSIZE, AWPROT, ARPROT;
  logic [1:0]  AWBURST, ARBURST;
  logic [15:0] AWID, ARID, RID, BID;
  logic [9:0]  AWUSER, ARUSER, WUSER, RUSER, BUSER;
  logic [3:0]  AWREGION, AWCACHE, AWQOS, ARREGION, ARCACHE, ARQOS;
  logic        WVALID, WREADY, WLAST, RVALID, RREADY, RLAST, BVALID, BREADY;
  logic [63:0] WDATA, RDATA, D, Q;
  logic [7:0]  WSTRB, BE;
  logic [1:0]  RRESP, BRESP;
  logic        CEN, WEN;
  logic [12:0] A;

  logic [63:0] mem [8192];
  rbeat_t      rq[$];
  int          checks, errors, rd_cnt, snap;
  time         ar_t, aw_t;

  axi_mem_if_slave dut (
    .ACLK(clk), .ARESET(ARESET), .test_en_i(test_en),
    .AWVALID_i(AWVALID), .AWREADY_o(AWREADY), .AWADDR_i(AWADDR), .AWLEN_i(AWLEN),
    .AWSIZE_i(AWSIZE), .AWBURST_i(AWBURST), .AWID_i(AWID), .AWUSER_i(AWUSER),
    .AWPROT_i(AWPROT), .AWREGION_i(AWREGION), .AWLOCK_i(AWLOCK), .AWCACHE_i(AWCACHE),
    .AWQOS_i(AWQOS),
    .ARVALID_i(ARVALID), .ARREADY_o(ARREADY), .ARADDR_i(ARADDR), .ARLEN_i(ARLEN),
    .ARSIZE_i(ARSIZE), .ARBURST_i(ARBURST), .ARID_i(ARID), .ARUSER_i(ARUSER),
    .ARPROT_i(ARPROT), .ARREGION_i(ARREGION), .ARLOCK_i(ARLOCK), .ARCACHE_i(ARCACHE),
    .ARQOS_i(ARQOS),
    .WVALID_i(WVALID), .WREADY_o(WREADY), .WDATA_i(WDATA), .WSTRB_i(WSTRB), .WLAST_i(WLAST),
    .WUSER_i(WUSER),
    .RVALID_o(RVALID), .RREADY_i(RREADY), .RDATA_o(RDATA), .RRESP_o(RRESP), .RLAST_o(RLAST),
    .RID_o(RID), .RUSER_o(RUSER),
    .BVALID_o(BVALID), .BREADY_i(BREADY), .BRESP_o(BRESP), .BID_o(BID), .BUSER_o(BUSER),
    .CEN(CEN), .WEN(WEN), .A(A), .D(D), .BE(BE), .Q(Q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM model: byte-enabled write, read data one cycle after the access.
  always @(posedge clk) begin
    if (!CEN) begin
      if (!WEN) begin
        for (int b = 0; b < 8; b++) if (BE[b]) mem[A][b*8 +: 8] <= D[b*8 +: 8];
      end else begin
        Q <= mem[A];
      end
    end
  end

  // Inputs only change on the falling edge, so this sees the values the next rising edge uses.
  always @(negedge clk) begin
    #2;
    if (!ARESET) begin
      if (RVALID && RREADY) rq.push_back('{RDATA, RLAST, RID, RUSER, RRESP});
      if (!CEN && WEN) rd_cnt <= rd_cnt + 1;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired got=running exp=finished");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic aw_send(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst,
                         input logic [15:0] id);
    int n = 0;
    @(negedge clk);
    AWADDR = addr; AWLEN = len; AWSIZE = 3'd3; AWBURST = burst; AWID = id;
    AWUSER = id[9:0]; AWVALID = 1'b1;
    #1;
    while (!AWREADY && n < 100) begin @(negedge clk); #1; n++; end
    aw_t = $time;
    check("aw_handshake", 64'(AWREADY), 64'd1);
    @(negedge clk);
    AWVALID = 1'b0;
  endtask

  task automatic ar_send(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst,
                         input logic [15:0] id);
    int n = 0;
    @(negedge clk);
    ARADDR = addr; ARLEN = len; ARSIZE = 3'd3; ARBURST = burst; ARID = id;
    ARUSER = id[9:0]; ARVALID = 1'b1;
    #1;
    while (!ARREADY && n < 100) begin @(negedge clk); #1; n++; end
    ar_t = $time;
    check("ar_handshake", 64'(ARREADY), 64'd1);
    @(negedge clk);
    ARVALID = 1'b0;
  endtask

  task automatic w_send(input logic [63:0] d, input logic [7:0] s, input logic l);
    int n = 0;
    WDATA = d; WSTRB = s; WLAST = l; WVALID = 1'b1;
    #1;
    while (!WREADY && n < 100) begin @(negedge clk); #1; n++; end
    check("w_handshake", 64'(WREADY), 64'd1);
    @(negedge clk);
    WVALID = 1'b0;
  endtask

  task automatic b_recv(input logic [15:0] id);
    int n = 0;
    BREADY = 1'b1;
    #1;
    while (!BVALID && n < 100) begin @(negedge clk); #1; n++; end
    check("bvalid", 64'(BVALID), 64'd1);
    check("bid", 64'(BID), 64'(id));
    check("bresp", 64'(BRESP), 64'd0);
    @(negedge clk);
    BREADY = 1'b0;
  endtask

  task automatic r_wait(input int nb, input bit rnd);
    int n = 0;
    while (rq.size() < nb && n < 400) begin
      @(negedge clk);
      RREADY = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      n++;
    end
    RREADY = 1'b1;
    repeat (3) @(negedge clk);
    check("r_beat_count", 64'(rq.size()), 64'(nb));
  endtask

  task automatic r_check(input logic [63:0] d, input logic l, input logic [15:0] id);
    rbeat_t b;
    check("r_present", 64'(rq.size() != 0), 64'd1);
    if (rq.size() != 0) begin
      b = rq.pop_front();
      check("rdata", b.d, d);
      check("rlast", 64'(b.l), 64'(l));
      check("rid", 64'(b.id), 64'(id));
      check("ruser", 64'(b.user), 64'(id[9:0]));
      check("rresp", 64'(b.resp), 64'd0);
    end
  endtask

  initial begin
    checks = 0; errors = 0; rd_cnt = 0;
    ARESET = 1'b1; test_en = 1'b0;
    AWVALID = 0; AWADDR = 0; AWLEN = 0; AWSIZE = 0; AWBURST = 0; AWID = 0; AWUSER = 0;
    AWPROT = 0; AWREGION = 0; AWLOCK = 0; AWCACHE = 0; AWQOS = 0;
    ARVALID = 0; ARADDR = 0; ARLEN = 0; ARSIZE = 0; ARBURST = 0; ARID = 0; ARUSER = 0;
    ARPROT = 0; ARREGION = 0; ARLOCK = 0; ARCACHE = 0; ARQOS = 0;
    WVALID = 0; WDATA = 0; WSTRB = 0; WLAST = 0; WUSER = 0;
    RREADY = 1'b1; BREADY = 1'b0;

    // Reset state
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("rst_awready", 64'(AWREADY), 64'd0);
    check("rst_arready", 64'(ARREADY), 64'd0);
    check("rst_wready", 64'(WREADY), 64'd0);
    check("rst_rvalid", 64'(RVALID), 64'd0);
    check("rst_bvalid", 64'(BVALID), 64'd0);
    check("rst_cen", 64'(CEN), 64'd1);
    check("rst_wen", 64'(WEN), 64'd1);
    check("rst_a", 64'(A), 64'd0);
    check("rst_rdata", RDATA, 64'd0);
    ARESET = 1'b0;
    @(negedge clk); #1;
    check("idle_awready", 64'(AWREADY), 64'd0);
    check("idle_arready", 64'(ARREADY), 64'd0);
    // W before AW must be refused
    @(negedge clk);
    WVALID = 1'b1; WDATA = 64'hDEAD; WSTRB = 8'hFF; WLAST = 1'b1;
    #1;
    check("early_w_wready", 64'(WREADY), 64'd0);
    @(negedge clk); #1;
    check("early_w_wready2", 64'(WREADY), 64'd0);
    check("early_w_cen", 64'(CEN), 64'd1);
    @(negedge clk);
    WVALID = 1'b0;

    // INCR write of four beats to 0x100
    aw_send(32'h100, 8'd3, 2'b01, 16'h1A2B);
    for (int i = 0; i < 4; i++) w_send(64'(17 * (i + 1)), 8'hFF, 1'(i == 3));
    b_recv(16'h1A2B);
    for (int i = 0; i < 4; i++) check("wr_mem", mem[13'h20 + 13'(i)], 64'(17 * (i + 1)));

    // INCR read back, RREADY held high
    ar_send(32'h100, 8'd3, 2'b01, 16'h00A5);
    r_wait(4, 1'b0);
    for (int i = 0; i < 4; i++) r_check(64'(17 * (i + 1)), 1'(i == 3), 16'h00A5);

    // Same read with random RREADY
    ar_send(32'h100, 8'd3, 2'b01, 16'h0033);
    r_wait(4, 1'b1);
    for (int i = 0; i < 4; i++) r_check(64'(17 * (i + 1)), 1'(i == 3), 16'h0033);

    // Eight-beat read with RREADY low: only FIFO-depth reads may be issued
    aw_send(32'h140, 8'd7, 2'b01, 16'h0002);
    for (int i = 0; i < 8; i++) w_send(64'h100 + 64'(i), 8'hFF, 1'(i == 7));
    b_recv(16'h0002);
    RREADY = 1'b0;
    snap = rd_cnt;
    ar_send(32'h140, 8'd7, 2'b01, 16'h0003);
    repeat (12) @(negedge clk);
    #1;
    check("stall_reads", 64'(rd_cnt - snap), 64'd4);
    check("stall_rvalid", 64'(RVALID), 64'd1);
    check("stall_rdata", RDATA, 64'h100);
    @(negedge clk); #1;
    check("stall_rdata_hold", RDATA, 64'h100);
    check("stall_cen", 64'(CEN), 64'd1);
    r_wait(8, 1'b0);
    for (int i = 0; i < 8; i++) r_check(64'h100 + 64'(i), 1'(i == 7), 16'h0003);

    // Simultaneous AR/AW: first tie to read, next tie to write
    fork
      begin
        aw_send(32'h208, 8'd0, 2'b01, 16'h0008);
        w_send(64'hBEEF, 8'hFF, 1'b1);
        b_recv(16'h0008);
      end
      ar_send(32'h100, 8'd0, 2'b01, 16'h0007);
    join
    check("tie1_read_first", 64'(ar_t < aw_t), 64'd1);
    r_wait(1, 1'b0);
    r_check(64'h11, 1'b1, 16'h0007);
    check("tie1_wr_mem", mem[13'h41], 64'hBEEF);
    fork
      begin
        aw_send(32'h210, 8'd0, 2'b01, 16'h000A);
        w_send(64'hCAFE, 8'hFF, 1'b1);
        b_recv(16'h000A);
      end
      ar_send(32'h100, 8'd0, 2'b01, 16'h0009);
    join
    check("tie2_write_first", 64'(aw_t < ar_t), 64'd1);
    r_wait(1, 1'b0);
    r_check(64'h11, 1'b1, 16'h0009);
    check("tie2_wr_mem", mem[13'h42], 64'hCAFE);

    // WRAP write from 0x118 then a low-half strobe write, read back with WRAP
    aw_send(32'h118, 8'd3, 2'b10, 16'h000B);
    for (int i = 0; i < 4; i++) w_send(64'hA0A1A2A3_00000000 + 64'(i), 8'hFF, 1'(i == 3));
    b_recv(16'h000B);
    check("wrap_w0", mem[13'h23], 64'hA0A1A2A3_00000000);
    check("wrap_w1", mem[13'h20], 64'hA0A1A2A3_00000001);
    check("wrap_w2", mem[13'h21], 64'hA0A1A2A3_00000002);
    check("wrap_w3", mem[13'h22], 64'hA0A1A2A3_00000003);
    aw_send(32'h100, 8'd0, 2'b01, 16'h000C);
    w_send(64'h55555555_66666666, 8'h0F, 1'b1);
    b_recv(16'h000C);
    ar_send(32'h118, 8'd3, 2'b10, 16'h000D);
    r_wait(4, 1'b0);
    r_check(64'hA0A1A2A3_00000000, 1'b0, 16'h000D);
    r_check(64'hA0A1A2A3_66666666, 1'b0, 16'h000D);
    r_check(64'hA0A1A2A3_00000002, 1'b0, 16'h000D);
    r_check(64'hA0A1A2A3_00000003, 1'b1, 16'h000D);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
